// File: rtl/core_mem_subsystem_if.sv
// Core-side memory bus plus the UART transmit stream of core_mem_subsystem.
// UART stream handshake: a byte transfers on every rising clk edge where
// uart_tx_valid && uart_tx_ready; valid never depends on ready, and the head
// byte stays stable while valid is high and ready is low.
interface core_mem_subsystem_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_raddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbit_en;
  logic [31:0] mem_rdata;
  logic        access_fault;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;

  modport slave (
    input  mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en, uart_tx_ready,
    output mem_rdata, access_fault, uart_tx_valid, uart_tx_data
  );

  modport master (
    output mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en, uart_tx_ready,
    input  mem_rdata, access_fault, uart_tx_valid, uart_tx_data
  );
endinterface

// File: rtl/core_mem_subsystem.sv
// Memory/MMIO target behind the core: word RAM with byte-lane stores,
// UART transmit FIFO with sticky overflow, and a 64-bit timer with a
// snapshot register for tear-free low-then-high reads.
module core_mem_subsystem #(
  parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
  parameter int          RAM_WORDS  = 16384,
  parameter logic [31:0] UART_ADDR  = 32'hA000_03F8,
  parameter logic [31:0] TIMER_ADDR = 32'hA000_0048,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn_in,
  core_mem_subsystem_if.slave  bus
);
  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;
  localparam logic [31:0] TIMER_HI  = TIMER_ADDR + 32'd4;

  logic [31:0] mem_q [RAM_WORDS];

  logic [31:0]      rdata_q, rdata_d;
  logic             fault_q, fault_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [63:0]      timer_q;
  logic [31:0]      snap_q, snap_d;

  // Address decode and store-lane generation
  logic [31:0]      ram_off;
  logic             ram_hit, uart_hit, tlo_hit, thi_hit, unmapped;
  logic [IDX_W-1:0] ram_idx;
  logic [1:0]       off;
  logic             size_ok, wr_en, spill;
  logic [3:0]       size_mask, lane_mask;
  logic [31:0]      wdata_sh;
  logic             push_req, push_ok, pop, full;
  logic [31:0]      uart_status;

  assign ram_off  = bus.mem_raddr - RAM_BASE;
  assign ram_hit  = ram_off < RAM_BYTES;
  assign ram_idx  = ram_off[IDX_W+1:2];
  assign off      = bus.mem_raddr[1:0];
  assign uart_hit = bus.mem_raddr == UART_ADDR;
  assign tlo_hit  = bus.mem_raddr == TIMER_ADDR;
  assign thi_hit  = bus.mem_raddr == TIMER_HI;
  assign unmapped = !(ram_hit || uart_hit || tlo_hit || thi_hit);

  assign size_ok  = (bus.mem_wbit_en == 4'd1) || (bus.mem_wbit_en == 4'd2) ||
                    (bus.mem_wbit_en == 4'd4);
  assign wr_en    = bus.mem_wr && size_ok;
  // Lanes past byte 3 fall off the top of the 4-bit mask; that spill is a fault.
  assign lane_mask = size_mask << off;
  assign spill     = wr_en && ram_hit &&
                     (({1'b0, off} + bus.mem_wbit_en[2:0]) > 3'd4);
  assign wdata_sh  = bus.mem_wdata << {off, 3'b000};

  assign full     = count_q == CNT_W'(FIFO_DEPTH);
  assign pop      = (count_q != '0) && bus.uart_tx_ready;
  assign push_req = wr_en && uart_hit;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok  = push_req && (!full || pop);

  assign uart_status = {ovf_q, {(31-CNT_W){1'b0}}, count_q};

  // Store size to lane pattern anchored at lane 0
  always_comb begin
    size_mask = 4'b0000;
    case (bus.mem_wbit_en)
      4'd1:    size_mask = 4'b0001;
      4'd2:    size_mask = 4'b0011;
      4'd4:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  // Read mux, fault detection, FIFO count and overflow next-state
  always_comb begin
    rdata_d = rdata_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    fault_d = spill || (unmapped && (bus.mem_rd || wr_en));
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    if (bus.mem_rd) begin
      if (ram_hit) begin
        rdata_d = mem_q[ram_idx] >> {off, 3'b000};
      end else if (uart_hit) begin
        rdata_d = uart_status;
        ovf_d   = 1'b0;
      end else if (tlo_hit) begin
        rdata_d = timer_q[31:0];
        snap_d  = timer_q[63:32];
      end else if (thi_hit) begin
        rdata_d = snap_q;
      end else begin
        rdata_d = 32'h0;
      end
    end
    // A dropped byte in the same cycle as a status read stays visible.
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  // RAM byte-lane store; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem_q[ram_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Read data, fault pulse, timer and snapshot registers
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
      timer_q <= '0;
      snap_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      timer_q <= timer_q + 64'd1;
      snap_q  <= snap_d;
    end
  end

  // UART FIFO storage, pointers, count and sticky overflow
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= bus.mem_wdata[7:0];
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.mem_rdata     = rdata_q;
  assign bus.access_fault  = fault_q;
  assign bus.uart_tx_valid = count_q != '0;
  assign bus.uart_tx_data  = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_core_mem_subsystem.sv
// Directed bench for core_mem_subsystem: RAM alignment/lanes, read-before-
// write, UART FIFO overflow and simultaneous push/pop, timer snapshot,
// unmapped accesses and asynchronous reset.
module tb_core_mem_subsystem;
  localparam logic [31:0] UART_ADDR  = 32'hA000_03F8;
  localparam logic [31:0] TIMER_ADDR = 32'hA000_0048;

  logic clk;
  logic rstn_in;
  int   tests = 0;
  int   fails = 0;

  core_mem_subsystem_if bus_if();

  core_mem_subsystem dut (
    .clk     (clk),
    .rstn_in (rstn_in),
    .bus     (bus_if)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, observed running required done");
    $fatal(1);
  end

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, pass one posedge, release the request
  task automatic cycle(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus_if.mem_rd      = rd;
    bus_if.mem_wr      = wr;
    bus_if.mem_raddr   = addr;
    bus_if.mem_wdata   = wdata;
    bus_if.mem_wbit_en = be;
    @(negedge clk);
    bus_if.mem_rd = 1'b0;
    bus_if.mem_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    cycle(1'b0, 1'b1, addr, data, be);
  endtask

  task automatic rd(input logic [31:0] addr);
    cycle(1'b1, 1'b0, addr, 32'h0, 4'd0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
  endtask

  initial begin
    rstn_in              = 1'b0;
    bus_if.mem_rd        = 1'b0;
    bus_if.mem_wr        = 1'b0;
    bus_if.mem_raddr     = '0;
    bus_if.mem_wdata     = '0;
    bus_if.mem_wbit_en   = '0;
    bus_if.uart_tx_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rdata", bus_if.mem_rdata, 32'h0);
    check("rst_fault", 32'(bus_if.access_fault), 32'h0);
    check("rst_valid", 32'(bus_if.uart_tx_valid), 32'h0);
    check("rst_txdata", 32'(bus_if.uart_tx_data), 32'h0);
    rstn_in = 1'b1;
    @(negedge clk);
    rd(UART_ADDR);
    check("rst_status", bus_if.mem_rdata, 32'h0);

    // Word store then offset reads
    wr(32'h8000_0100, 32'h1122_3344, 4'd4);
    check("sw_fault", 32'(bus_if.access_fault), 32'h0);
    rd(32'h8000_0101);
    check("rd_off1", bus_if.mem_rdata, 32'h0011_2233);
    rd(32'h8000_0103);
    check("rd_off3", bus_if.mem_rdata, 32'h0000_0011);
    rd(32'h8000_0100);
    check("rd_off0", bus_if.mem_rdata, 32'h1122_3344);
    idle();
    check("rd_hold", bus_if.mem_rdata, 32'h1122_3344);

    // Sub-word stores and lane spill
    wr(32'h8000_0200, 32'hFFFF_FFFF, 4'd4);
    wr(32'h8000_0202, 32'h0000_00AB, 4'd1);
    rd(32'h8000_0200);
    check("sb_off2", bus_if.mem_rdata, 32'hFFAB_FFFF);
    wr(32'h8000_0203, 32'h0000_BEEF, 4'd2);
    check("sh_spill_fault", 32'(bus_if.access_fault), 32'h1);
    idle();
    check("sh_spill_pulse", 32'(bus_if.access_fault), 32'h0);
    rd(32'h8000_0200);
    check("sh_spill_data", bus_if.mem_rdata, 32'hEFAB_FFFF);
    wr(32'h8000_0201, 32'h0000_1234, 4'd2);
    check("sh_off1_fault", 32'(bus_if.access_fault), 32'h0);
    wr(32'h8000_0200, 32'h0000_0000, 4'd3);
    rd(32'h8000_0200);
    check("sh_off1_bad_size", bus_if.mem_rdata, 32'hEF12_34FF);
    wr(32'h8000_0201, 32'hCAFE_BABE, 4'd4);
    check("sw_off1_fault", 32'(bus_if.access_fault), 32'h1);
    rd(32'h8000_0200);
    check("sw_off1_data", bus_if.mem_rdata, 32'hFEBA_BEFF);

    // Read-before-write on the same word
    wr(32'h8000_0300, 32'h9, 4'd4);
    cycle(1'b1, 1'b1, 32'h8000_0300, 32'h5, 4'd4);
    check("rbw_old", bus_if.mem_rdata, 32'h9);
    rd(32'h8000_0300);
    check("rbw_new", bus_if.mem_rdata, 32'h5);

    // UART overflow with sink stalled
    for (int i = 1; i <= 5; i++) wr(UART_ADDR, 32'(i), 4'd1);
    check("uart_valid_full", 32'(bus_if.uart_tx_valid), 32'h1);
    check("uart_head_full", 32'(bus_if.uart_tx_data), 32'h1);
    rd(UART_ADDR);
    check("uart_status_ovf", bus_if.mem_rdata, 32'h8000_0004);
    rd(UART_ADDR);
    check("uart_status_clr", bus_if.mem_rdata, 32'h0000_0004);
    bus_if.uart_tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("uart_drain_valid%0d", i), 32'(bus_if.uart_tx_valid), 32'h1);
      check($sformatf("uart_drain_data%0d", i), 32'(bus_if.uart_tx_data), 32'(i));
      @(negedge clk);
    end
    check("uart_empty", 32'(bus_if.uart_tx_valid), 32'h0);
    bus_if.uart_tx_ready = 1'b0;

    // Full FIFO, push and pop in the same cycle
    wr(UART_ADDR, 32'h10, 4'd1);
    wr(UART_ADDR, 32'h20, 4'd1);
    wr(UART_ADDR, 32'h30, 4'd1);
    wr(UART_ADDR, 32'h40, 4'd1);
    bus_if.uart_tx_ready = 1'b1;
    wr(UART_ADDR, 32'h55, 4'd1);
    bus_if.uart_tx_ready = 1'b0;
    check("pushpop_head", 32'(bus_if.uart_tx_data), 32'h20);
    rd(UART_ADDR);
    check("pushpop_status", bus_if.mem_rdata, 32'h0000_0004);
    bus_if.uart_tx_ready = 1'b1;
    check("pushpop_d0", 32'(bus_if.uart_tx_data), 32'h20);
    @(negedge clk);
    check("pushpop_d1", 32'(bus_if.uart_tx_data), 32'h30);
    @(negedge clk);
    check("pushpop_d2", 32'(bus_if.uart_tx_data), 32'h40);
    @(negedge clk);
    check("pushpop_d3", 32'(bus_if.uart_tx_data), 32'h55);
    @(negedge clk);
    check("pushpop_empty", 32'(bus_if.uart_tx_valid), 32'h0);
    bus_if.uart_tx_ready = 1'b0;

    // Push into an empty FIFO while ready is already high
    bus_if.uart_tx_ready = 1'b1;
    wr(UART_ADDR, 32'h66, 4'd1);
    bus_if.uart_tx_ready = 1'b0;
    check("empty_push_valid", 32'(bus_if.uart_tx_valid), 32'h1);
    check("empty_push_data", 32'(bus_if.uart_tx_data), 32'h66);
    bus_if.uart_tx_ready = 1'b1;
    @(negedge clk);
    bus_if.uart_tx_ready = 1'b0;

    // Timer snapshot across the low-word carry
    force dut.timer_q = 64'h0000_0000_FFFF_FFFF;
    bus_if.mem_rd    = 1'b1;
    bus_if.mem_raddr = TIMER_ADDR;
    #1;
    release dut.timer_q;
    @(negedge clk);
    bus_if.mem_rd = 1'b0;
    check("timer_lo", bus_if.mem_rdata, 32'hFFFF_FFFF);
    idle();
    idle();
    rd(TIMER_ADDR + 32'd4);
    check("timer_snap_hi", bus_if.mem_rdata, 32'h0000_0000);
    rd(TIMER_ADDR);
    rd(TIMER_ADDR + 32'd4);
    check("timer_live_hi", bus_if.mem_rdata, 32'h0000_0001);
    wr(TIMER_ADDR, 32'h1234_5678, 4'd4);
    check("timer_wr_nofault", 32'(bus_if.access_fault), 32'h0);

    // Unmapped accesses
    rd(32'h8000_0300);
    rd(32'h9000_0000);
    check("unmapped_rd_data", bus_if.mem_rdata, 32'h0);
    check("unmapped_rd_fault", 32'(bus_if.access_fault), 32'h1);
    wr(32'h9000_0000, 32'hDEAD_BEEF, 4'd4);
    check("unmapped_wr_fault", 32'(bus_if.access_fault), 32'h1);
    idle();
    check("unmapped_fault_clr", 32'(bus_if.access_fault), 32'h0);
    rd(32'h8001_0000);
    check("ram_end_fault", 32'(bus_if.access_fault), 32'h1);
    rd(32'h8000_FFFC);
    check("ram_last_fault", 32'(bus_if.access_fault), 32'h0);

    // Asynchronous reset during activity
    wr(UART_ADDR, 32'h77, 4'd1);
    wr(UART_ADDR, 32'h88, 4'd1);
    bus_if.mem_rd    = 1'b1;
    bus_if.mem_raddr = 32'h8000_0300;
    @(posedge clk);
    #1;
    rstn_in = 1'b0;
    #1;
    check("arst_rdata", bus_if.mem_rdata, 32'h0);
    check("arst_valid", 32'(bus_if.uart_tx_valid), 32'h0);
    @(negedge clk);
    bus_if.mem_rd = 1'b0;
    rstn_in = 1'b1;
    idle();
    check("arst_rdata_after", bus_if.mem_rdata, 32'h0);
    rd(UART_ADDR);
    check("arst_status", bus_if.mem_rdata, 32'h0);
    rd(32'h8000_0300);
    check("arst_ram_kept", bus_if.mem_rdata, 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
